// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the RV32 core. Captures decoded fields from the
// decode stage, forwards EX/MEM and MEM/WB results into the ALU operands,
// detects load-use hazards (one-cycle stall plus a bubble), and squashes the
// captured instruction on a branch/jump flush.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_*                            decoded instruction fields from decode
//   exmem_reg_write/rd/result       EX/MEM forwarding source
//   memwb_reg_write/rd/result       MEM/WB forwarding source
//   flush                           squash the instruction being captured
//   stall                           hold PC and IF/ID this cycle (comb)
//   ex_valid, ex_pc, ex_rd,
//   ex_alu_ctl                      registered fields
//   ex_a, ex_b, ex_store_data       forwarded/muxed ALU operands (comb)
//   ex_reg_write/mem_read/mem_write registered control, 0 when not valid
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_ctl,
    input  logic            id_src_a_pc,
    input  logic            id_src_b_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            flush,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd,
    output logic [3:0]      ex_alu_ctl,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
);

    logic            valid_q,     valid_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [RA_W-1:0] rs1_q,       rs1_d;
    logic [RA_W-1:0] rs2_q,       rs2_d;
    logic [RA_W-1:0] rd_q,        rd_d;
    logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [3:0]      alu_ctl_q,   alu_ctl_d;
    logic            src_a_pc_q,  src_a_pc_d;
    logic            src_b_imm_q, src_b_imm_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q,  mem_read_d;
    logic            mem_write_q, mem_write_d;

    logic            load_use;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // A load in EX whose result the instruction in ID needs cannot be
    // forwarded in time; x0 is never a real dependency.
    always_comb begin
        load_use = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                   ((id_use_rs1 & (id_rs1 == rd_q)) |
                    (id_use_rs2 & (id_rs2 == rd_q)));
    end

    // A flush discards the instruction in ID anyway, so holding it is pointless.
    assign stall = load_use & ~flush;

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        alu_ctl_d   = alu_ctl_q;
        src_a_pc_d  = src_a_pc_q;
        src_b_imm_d = src_b_imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (flush || load_use) begin
            // Bubble: register numbers cleared so nothing forwards into it.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            rd_d        = '0;
            rs1_d       = '0;
            rs2_d       = '0;
        end else begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            alu_ctl_d   = id_alu_ctl;
            src_a_pc_d  = id_src_a_pc;
            src_b_imm_d = id_src_b_imm;
            reg_write_d = id_reg_write & id_valid;
            mem_read_d  = id_mem_read  & id_valid;
            mem_write_d = id_mem_write & id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_ctl_q   <= '0;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            alu_ctl_q   <= alu_ctl_d;
            src_a_pc_q  <= src_a_pc_d;
            src_b_imm_q <= src_b_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // EX/MEM is the younger result and wins over MEM/WB.
    always_comb begin
        if (exmem_reg_write && (exmem_rd == rs1_q) && (rs1_q != '0))
            fwd_rs1 = exmem_result;
        else if (memwb_reg_write && (memwb_rd == rs1_q) && (rs1_q != '0))
            fwd_rs1 = memwb_result;
        else
            fwd_rs1 = rs1_data_q;

        if (exmem_reg_write && (exmem_rd == rs2_q) && (rs2_q != '0))
            fwd_rs2 = exmem_result;
        else if (memwb_reg_write && (memwb_rd == rs2_q) && (rs2_q != '0))
            fwd_rs2 = memwb_result;
        else
            fwd_rs2 = rs2_data_q;
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rd         = rd_q;
    assign ex_alu_ctl    = alu_ctl_q;
    assign ex_a          = src_a_pc_q  ? pc_q  : fwd_rs1;
    assign ex_b          = src_b_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_reg_write  = reg_write_q & valid_q;
    assign ex_mem_read   = mem_read_q  & valid_q;
    assign ex_mem_write  = mem_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_ctl;
    logic        id_src_a_pc, id_src_b_imm;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_ctl;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alu_ctl(id_alu_ctl),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_alu_ctl(ex_alu_ctl), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled shortly after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 0; id_alu_ctl = 0; id_src_a_pc = 0; id_src_b_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
        flush = 0;
    endtask

    // Put "lw x<rd>, 4(x1)" into ID so it lands in EX after the next edge.
    task automatic drive_load(input logic [4:0] rd, input logic [31:0] pc);
        idle_inputs();
        id_valid = 1; id_pc = pc; id_rs1 = 1; id_use_rs1 = 1;
        id_rs1_data = 32'h1000; id_imm = 4; id_src_b_imm = 1;
        id_rd = rd; id_reg_write = 1; id_mem_read = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEADBEEF;
        id_valid = 1; id_pc = 32'h44; id_rd = 3; id_reg_write = 1;
        repeat (3) tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_rd !== 5'd0 || ex_alu_ctl !== 4'h0) begin
            errors++;
            $display("FAIL reset_fields: valid=%b pc=%h rd=%0d alu=%h, want 0 0 0 0",
                     ex_valid, ex_pc, ex_rd, ex_alu_ctl);
        end
        checks++;
        if (ex_a !== 32'h0 || ex_b !== 32'h0 || ex_store_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_operands: a=%h b=%h sd=%h, want 0", ex_a, ex_b, ex_store_data);
        end
        checks++;
        if ({ex_reg_write, ex_mem_read, ex_mem_write, stall} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl: rw/mr/mw/stall=%b, want 0000",
                     {ex_reg_write, ex_mem_read, ex_mem_write, stall});
        end
        idle_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_plain_capture();
        idle_inputs();
        id_valid = 1; id_pc = 32'h100; id_rs1 = 1; id_use_rs1 = 1;
        id_rs1_data = 5; id_imm = 7; id_src_b_imm = 1; id_alu_ctl = 4'h0;
        id_rd = 2; id_reg_write = 1;
        #1;
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL capture_latency: ex_valid=%b before edge, want 0", ex_valid);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_a !== 32'd5 || ex_b !== 32'd7 || ex_pc !== 32'h100) begin
            errors++;
            $display("FAIL plain_capture: valid=%b a=%h b=%h pc=%h, want 1 5 7 100",
                     ex_valid, ex_a, ex_b, ex_pc);
        end
        checks++;
        if (ex_rd !== 5'd2 || ex_reg_write !== 1'b1 || ex_mem_read !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL plain_ctl: rd=%0d rw=%b mr=%b stall=%b, want 2 1 0 0",
                     ex_rd, ex_reg_write, ex_mem_read, stall);
        end
    endtask

    task automatic test_src_a_pc();
        idle_inputs();
        id_valid = 1; id_pc = 32'h200; id_rs1 = 3; id_rs1_data = 32'h33;
        id_src_a_pc = 1; id_imm = 32'hFFFF_F000; id_src_b_imm = 1; id_alu_ctl = 4'h9;
        tick();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
        #1;
        checks++;
        if (ex_a !== 32'h200 || ex_b !== 32'hFFFF_F000 || ex_alu_ctl !== 4'h9) begin
            errors++;
            $display("FAIL src_a_pc: a=%h b=%h alu=%h, want 200 fffff000 9", ex_a, ex_b, ex_alu_ctl);
        end
    endtask

    task automatic test_forward_priority();
        idle_inputs();
        id_valid = 1; id_pc = 32'h300; id_rs1 = 3; id_rs2 = 4;
        id_use_rs1 = 1; id_use_rs2 = 1; id_rs1_data = 32'h33; id_rs2_data = 32'h44;
        id_rd = 6; id_reg_write = 1;
        tick();
        idle_inputs();
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h22;
        #1;
        checks++;
        if (ex_a !== 32'h11) begin
            errors++;
            $display("FAIL fwd_exmem_priority: a=%h, want 11", ex_a);
        end
        exmem_reg_write = 0;
        #1;
        checks++;
        if (ex_a !== 32'h22) begin
            errors++;
            $display("FAIL fwd_memwb: a=%h, want 22", ex_a);
        end
        memwb_reg_write = 0;
        #1;
        checks++;
        if (ex_a !== 32'h33 || ex_b !== 32'h44) begin
            errors++;
            $display("FAIL fwd_none: a=%h b=%h, want 33 44", ex_a, ex_b);
        end
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h55;
        #1;
        checks++;
        if (ex_b !== 32'h55 || ex_store_data !== 32'h55 || ex_a !== 32'h33) begin
            errors++;
            $display("FAIL fwd_rs2: a=%h b=%h sd=%h, want 33 55 55", ex_a, ex_b, ex_store_data);
        end
    endtask

    task automatic test_load_use();
        drive_load(5'd5, 32'h400);
        tick();
        idle_inputs();
        id_valid = 1; id_pc = 32'h404; id_rs1 = 6; id_rs2 = 5;
        id_use_rs1 = 1; id_use_rs2 = 1; id_rs1_data = 32'h66; id_rs2_data = 32'hAA;
        id_rd = 7; id_reg_write = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b, want 1", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: valid=%b rd=%0d rw=%b mr=%b, want 0 0 0 0",
                     ex_valid, ex_rd, ex_reg_write, ex_mem_read);
        end
        checks++;
        if (stall !== 1'b0 || ex_pc !== 32'h400) begin
            errors++;
            $display("FAIL load_use_one_cycle: stall=%b pc=%h, want 0 400", stall, ex_pc);
        end
        tick();
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h99;
        #1;
        checks++;
        if (ex_valid !== 1'b1 || ex_b !== 32'h99 || ex_a !== 32'h66 || ex_rd !== 5'd7) begin
            errors++;
            $display("FAIL load_use_capture: valid=%b a=%h b=%h rd=%0d, want 1 66 99 7",
                     ex_valid, ex_a, ex_b, ex_rd);
        end
    endtask

    task automatic test_flush_over_stall();
        drive_load(5'd5, 32'h500);
        tick();
        idle_inputs();
        id_valid = 1; id_pc = 32'h504; id_rs2 = 5; id_use_rs2 = 1; id_rd = 7; id_reg_write = 1;
        flush = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: stall=%b, want 0", stall);
        end
        tick();
        flush = 0; id_valid = 0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_pc !== 32'h500) begin
            errors++;
            $display("FAIL flush_bubble: valid=%b rw=%b mr=%b pc=%h, want 0 0 0 500",
                     ex_valid, ex_reg_write, ex_mem_read, ex_pc);
        end
    endtask

    task automatic test_no_stall_cases();
        drive_load(5'd5, 32'h600);
        tick();
        idle_inputs();
        id_valid = 0; id_rs1 = 5; id_rs2 = 5; id_use_rs1 = 1; id_use_rs2 = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL invalid_id_stall: stall=%b, want 0", stall);
        end
        id_valid = 1; id_use_rs1 = 0; id_use_rs2 = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL unused_rs_stall: stall=%b, want 0", stall);
        end
    endtask

    task automatic test_x0_guard();
        drive_load(5'd0, 32'h700);
        tick();
        idle_inputs();
        id_valid = 1; id_pc = 32'h704; id_rs1 = 0; id_use_rs1 = 1;
        id_rs1_data = 32'h1234; id_rd = 8; id_reg_write = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall: stall=%b, want 0", stall);
        end
        tick();
        idle_inputs();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (ex_a !== 32'h1234 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL x0_forward: a=%h valid=%b, want 1234 1", ex_a, ex_valid);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        id_valid = 1; id_pc = 32'h800; id_rd = 9; id_reg_write = 1; id_mem_write = 1;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_mem_write !== 1'b1) begin
            errors++;
            $display("FAIL pre_async_reset: valid=%b mw=%b, want 1 1", ex_valid, ex_mem_write);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_rd !== 5'd0 || ex_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b pc=%h rd=%0d mw=%b, want 0 0 0 0",
                     ex_valid, ex_pc, ex_rd, ex_mem_write);
        end
        tick();
        rst_n = 1;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h800) begin
            errors++;
            $display("FAIL post_reset_capture: valid=%b pc=%h, want 1 800", ex_valid, ex_pc);
        end
    endtask

    initial begin
        test_reset();
        test_plain_capture();
        test_src_a_pc();
        test_forward_priority();
        test_load_use();
        test_flush_over_stall();
        test_no_stall_cases();
        test_x0_guard();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
